// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive/transmit FSM state encoding and frame geometry.
package ps2_pkg;
    localparam int         PS2_DATA_BITS = 8;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;
endpackage

// File: rtl/ps2_sync_fall.sv
// Two-flop synchronisers for the PS/2 pins plus falling-edge detection of the PS/2 clock.
module ps2_sync_fall (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_s,
    output logic fall
);
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;

    // Reset to the idle-bus level so release from reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign data_s = data_sync[1];
endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host frame receiver with parity/framing checks, inter-edge watchdog
// and a one-entry valid/ready holding register.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 13
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     ps2_clk_i,
    input  logic                     ps2_data_i,
    input  logic                     enable_i,
    input  logic                     ready_i,
    output logic [PS2_DATA_BITS-1:0] data_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overflow_o
);
    logic                     data_s;
    logic                     fall;
    logic [1:0]               state;
    logic [1:0]               state_n;
    logic [PS2_DATA_BITS-1:0] shift;
    logic [2:0]               bit_cnt;
    logic                     parity_bit;
    logic [CNT_W-1:0]         wd;
    logic                     timeout;
    logic                     stop_edge;
    logic                     par_bad;
    logic                     stop_bad;
    logic                     load;
    logic                     ovf;
    logic                     wd_err;

    ps2_sync_fall u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .data_s     (data_s),
        .fall       (fall)
    );

    // A fall in the expiry cycle takes priority over the watchdog.
    assign timeout = (state != ST_IDLE) && !fall && (wd == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!enable_i) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (fall && !data_s) state_n = ST_DATA;
                ST_DATA:   if (fall && bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = ST_PARITY;
                           else if (timeout) state_n = ST_IDLE;
                ST_PARITY: if (fall) state_n = ST_STOP;
                           else if (timeout) state_n = ST_IDLE;
                ST_STOP:   if (fall || timeout) state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stop_edge = enable_i && (state == ST_STOP) && fall;
        par_bad   = stop_edge && !(^{shift, parity_bit});
        stop_bad  = stop_edge && !data_s;
        load      = stop_edge && !par_bad && !stop_bad && (!valid_o || ready_i);
        ovf       = stop_edge && !par_bad && !stop_bad && valid_o && !ready_i;
        wd_err    = enable_i && timeout;
    end

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shift        <= '0;
            bit_cnt      <= '0;
            parity_bit   <= 1'b0;
            wd           <= '0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            parity_err_o <= par_bad;
            frame_err_o  <= stop_bad | wd_err;
            overflow_o   <= ovf;

            if (state == ST_IDLE || fall) wd <= '0;
            else                          wd <= wd + CNT_W'(1);

            if (enable_i && fall) begin
                case (state)
                    ST_IDLE:   if (!data_s) bit_cnt <= '0;
                    ST_DATA:   begin
                        shift   <= {data_s, shift[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: parity_bit <= data_s;
                    default:   ;
                endcase
            end

            if (load) begin
                data_o  <= shift;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: good, parity, stop, watchdog, overflow, reset/enable cases.
module tb_ps2_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       enable = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, busy_o, parity_err_o, frame_err_o, overflow_o;

    int compared = 0;
    int mismatched = 0;

    int cyc = 0;
    int valid_cyc = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int ferr_at = 0;
    int last_fall = 0;

    ps2_rx_ctrl #(.TIMEOUT_CYC(200), .CNT_W(13)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .enable_i     (enable),
        .ready_i      (ready),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid_o)      valid_cyc <= valid_cyc + 1;
        if (parity_err_o) perr_cnt <= perr_cnt + 1;
        if (overflow_o)   ovf_cnt <= ovf_cnt + 1;
        if (frame_err_o) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_at  <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Sends the first n bits (start first, LSB first); data changes mid-high phase.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            tick(20);
            ps2_data = bits[i];
            tick(20);
            ps2_clk = 1'b0;
            last_fall = cyc;
            tick(40);
            ps2_clk = 1'b1;
        end
        tick(20);
        ps2_data = 1'b1;
        tick(40);
    endtask

    task automatic test_reset;
        tick(3);
        compared++;
        if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0 ||
            parity_err_o !== 1'b0 || frame_err_o !== 1'b0 || overflow_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got data=%h v=%b b=%b pe=%b fe=%b ov=%b, want all 0",
                     data_o, valid_o, busy_o, parity_err_o, frame_err_o, overflow_o);
        end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_good_frame;
        int v0, p0, f0;
        v0 = valid_cyc; p0 = perr_cnt; f0 = ferr_cnt;
        ready = 1'b1;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        compared++;
        if (valid_cyc - v0 !== 1) begin
            mismatched++;
            $display("FAIL good_valid_cycles: got %0d want 1", valid_cyc - v0);
        end
        compared++;
        if (data_o !== 8'h1C) begin
            mismatched++;
            $display("FAIL good_data: got %h want 1c", data_o);
        end
        compared++;
        if (perr_cnt - p0 !== 0 || ferr_cnt - f0 !== 0) begin
            mismatched++;
            $display("FAIL good_no_err: got perr=%0d ferr=%0d want 0 0", perr_cnt - p0, ferr_cnt - f0);
        end
        compared++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL good_idle_after: got busy=%b valid=%b want 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_parity_err;
        int v0, p0;
        v0 = valid_cyc; p0 = perr_cnt;
        send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
        compared++;
        if (perr_cnt - p0 !== 1) begin
            mismatched++;
            $display("FAIL parity_pulse: got %0d pulses want 1", perr_cnt - p0);
        end
        compared++;
        if (valid_cyc - v0 !== 0 || data_o !== 8'h1C) begin
            mismatched++;
            $display("FAIL parity_drop: got valid_cyc=%0d data=%h want 0 1c", valid_cyc - v0, data_o);
        end
    endtask

    task automatic test_stop_err;
        int v0, f0, p0;
        v0 = valid_cyc; f0 = ferr_cnt; p0 = perr_cnt;
        send_bits(frame(8'hF0, 1'b1, 1'b0), 11);
        compared++;
        if (ferr_cnt - f0 !== 1 || perr_cnt - p0 !== 0) begin
            mismatched++;
            $display("FAIL stop_pulse: got ferr=%0d perr=%0d want 1 0", ferr_cnt - f0, perr_cnt - p0);
        end
        compared++;
        if (valid_cyc - v0 !== 0) begin
            mismatched++;
            $display("FAIL stop_no_valid: got %0d valid cycles want 0", valid_cyc - v0);
        end
    endtask

    task automatic test_watchdog;
        int f0, v0, gap;
        f0 = ferr_cnt;
        send_bits(frame(8'hF0, 1'b1, 1'b1), 5);
        compared++;
        if (busy_o !== 1'b1) begin
            mismatched++;
            $display("FAIL wd_busy_mid: got %b want 1", busy_o);
        end
        tick(250);
        gap = ferr_at - last_fall;
        compared++;
        if (ferr_cnt - f0 !== 1 || gap < 198 || gap > 208) begin
            mismatched++;
            $display("FAIL wd_timeout: got pulses=%0d gap=%0d want 1 pulse gap~200", ferr_cnt - f0, gap);
        end
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL wd_idle: got busy=%b want 0", busy_o);
        end
        v0 = valid_cyc;
        send_bits(frame(8'hF0, 1'b1, 1'b1), 11);
        compared++;
        if (valid_cyc - v0 !== 1 || data_o !== 8'hF0) begin
            mismatched++;
            $display("FAIL wd_recover: got valid_cyc=%0d data=%h want 1 f0", valid_cyc - v0, data_o);
        end
    endtask

    task automatic test_overflow;
        int o0;
        o0 = ovf_cnt;
        ready = 1'b0;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        compared++;
        if (valid_o !== 1'b1 || data_o !== 8'h1C) begin
            mismatched++;
            $display("FAIL ovf_first: got valid=%b data=%h want 1 1c", valid_o, data_o);
        end
        send_bits(frame(8'h32, 1'b0, 1'b1), 11);
        compared++;
        if (ovf_cnt - o0 !== 1) begin
            mismatched++;
            $display("FAIL ovf_pulse: got %0d want 1", ovf_cnt - o0);
        end
        compared++;
        if (valid_o !== 1'b1 || data_o !== 8'h1C) begin
            mismatched++;
            $display("FAIL ovf_hold: got valid=%b data=%h want 1 1c", valid_o, data_o);
        end
        ready = 1'b1;
        tick(2);
        compared++;
        if (valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_drain: got valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 4);
        rst_n = 1'b0;
        tick(3);
        compared++;
        if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0 ||
            frame_err_o !== 1'b0 || parity_err_o !== 1'b0 || overflow_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid: got data=%h v=%b b=%b fe=%b want all 0", data_o, valid_o, busy_o, frame_err_o);
        end
        rst_n = 1'b1;
        tick(5);
        v0 = valid_cyc;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
        compared++;
        if (valid_cyc - v0 !== 1 || data_o !== 8'h1C) begin
            mismatched++;
            $display("FAIL rst_mid_recover: got valid_cyc=%0d data=%h want 1 1c", valid_cyc - v0, data_o);
        end
    endtask

    task automatic test_enable_mid;
        int v0, f0;
        f0 = ferr_cnt;
        send_bits(frame(8'hF0, 1'b1, 1'b1), 4);
        enable = 1'b0;
        tick(2);
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL en_idle: got busy=%b want 0", busy_o);
        end
        tick(250);
        compared++;
        if (ferr_cnt - f0 !== 0 || data_o !== 8'h1C) begin
            mismatched++;
            $display("FAIL en_silent: got ferr=%0d data=%h want 0 1c", ferr_cnt - f0, data_o);
        end
        enable = 1'b1;
        tick(5);
        v0 = valid_cyc;
        send_bits(frame(8'h32, 1'b0, 1'b1), 11);
        compared++;
        if (valid_cyc - v0 !== 1 || data_o !== 8'h32) begin
            mismatched++;
            $display("FAIL en_recover: got valid_cyc=%0d data=%h want 1 32", valid_cyc - v0, data_o);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_parity_err;
        test_stop_err;
        test_watchdog;
        test_overflow;
        test_reset_mid;
        test_enable_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
